// File: rtl/pacman_score_keeper.sv
// pacman_score_keeper: accumulates the Pac-Man score in BCD from gameplay event
// pulses and presents a frame-stable copy to the on-screen digit renderer.
//
// Parameters:
//   DIGITS    - number of BCD digits kept (1-4)
//   GHOST_PTS - points per ghost eaten (1-3)
//   PELLETS   - pellets per level (used only when SCORE_WIN_EN is defined)
// Ports:
//   clk_pix   - pixel clock, the only clock
//   rst_n     - asynchronous active-low reset
//   frame     - start-of-vblank pulse; loads the displayed score
//   clear     - new-game pulse; zeroes score (and pellet count), beats events
//   pellet    - normal pellet eaten (+1)
//   power     - power pellet eaten (+5)
//   ghost     - ghost eaten (+GHOST_PTS)
//   score_bcd - displayed score, digit 0 (ones) in [3:0]
//   saturated - running score is all nines
//   win       - level cleared
// Optional feature macro: SCORE_WIN_EN (pellet counter and win flag; when
// undefined, win is tied 0 and events are never blocked).
module pacman_score_keeper #(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned GHOST_PTS = 3,
    parameter int unsigned PELLETS   = 240
) (
    input  logic                  clk_pix,
    input  logic                  rst_n,
    input  logic                  frame,
    input  logic                  clear,
    input  logic                  pellet,
    input  logic                  power,
    input  logic                  ghost,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  saturated,
    output logic                  win
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    // Reject out-of-range configurations at elaboration.
    if (DIGITS < 1 || DIGITS > 4 || GHOST_PTS < 1 || GHOST_PTS > 3 || PELLETS < 1) begin : g_param_check
        $error("pacman_score_keeper: parameter out of range");
    end

    logic [W-1:0] run;
    logic [W-1:0] run_add;
    logic [W-1:0] run_next;
    logic         carry_out;
    logic         blocked;
    logic         pellet_ok;
    logic         power_ok;
    logic         ghost_ok;
    logic [3:0]   inc;
    logic [4:0]   addend;
    logic [4:0]   sum;

    assign pellet_ok = pellet & ~blocked;
    assign power_ok  = power  & ~blocked;
    assign ghost_ok  = ghost  & ~blocked;

    // Ripple BCD add: digit 0 takes the event increment (max 9), higher digits take the carry.
    always_comb begin
        inc       = (pellet_ok ? 4'd1 : 4'd0)
                  + (power_ok  ? 4'd5 : 4'd0)
                  + (ghost_ok  ? 4'(GHOST_PTS) : 4'd0);
        run_add   = '0;
        addend    = {1'b0, inc};
        sum       = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            sum = {1'b0, run[4*i +: 4]} + addend;
            if (sum >= 5'd10) begin
                run_add[4*i +: 4] = 4'(sum - 5'd10);
                addend            = 5'd1;
            end else begin
                run_add[4*i +: 4] = sum[3:0];
                addend            = 5'd0;
            end
        end
        carry_out = addend[0];
        if (clear) begin
            run_next = '0;
        end else if (carry_out) begin
            run_next = ALL_NINES;
        end else begin
            run_next = run_add;
        end
    end

    // Running score, saturation flag and frame-latched display copy.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            run       <= '0;
            score_bcd <= '0;
            saturated <= 1'b0;
        end else begin
            run       <= run_next;
            saturated <= (run_next == ALL_NINES);
            if (frame) begin
                score_bcd <= clear ? '0 : run;
            end
        end
    end

`ifdef SCORE_WIN_EN
    localparam int unsigned CNT_W = $clog2(PELLETS + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   cnt_sum;
    logic             reach;

    assign blocked = win;

    // Pellet and power pulses each count once; the count sticks at PELLETS.
    always_comb begin
        cnt_sum = {1'b0, cnt} + (CNT_W+1)'(pellet_ok) + (CNT_W+1)'(power_ok);
        reach   = (cnt_sum >= (CNT_W+1)'(PELLETS));
        if (clear) begin
            cnt_next = '0;
        end else if (reach) begin
            cnt_next = CNT_W'(PELLETS);
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            win <= 1'b0;
        end else begin
            cnt <= cnt_next;
            win <= clear ? 1'b0 : (win | reach);
        end
    end
`else
    assign blocked = 1'b0;
    assign win     = 1'b0;
`endif

endmodule
